// File: rtl/eight_bit_multiplier_pkg.sv
// rtl/eight_bit_multiplier_pkg.sv - shared constants for the truncating 8x8 multiplier
package eight_bit_multiplier_pkg;

    localparam int WIDTH        = 8;
    localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/eight_bit_adder.sv
// rtl/eight_bit_adder.sv - 8-bit ripple-carry adder built from full-adder equations
module eight_bit_adder
    import eight_bit_multiplier_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/eight_bit_multiplier.sv
// rtl/eight_bit_multiplier.sv - two-stage unsigned 8x8 multiplier returning (a*b) mod 256
module eight_bit_multiplier
    import eight_bit_multiplier_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    logic [WIDTH-1:0] rows [WIDTH];
    logic [WIDTH-1:0] acc  [WIDTH];
    logic [WIDTH-1:1] carry_unused;

    // Bits shifted past the MSB drop out here, so every row is already mod 256.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rows[i] = b_q[i] ? (a_q << i) : '0;
        end
    end

    assign acc[0] = rows[0];

    for (genvar g = 1; g < WIDTH; g++) begin : g_row
        eight_bit_adder u_add (
            .a_i    (acc[g-1]),
            .b_i    (rows[g]),
            .cin_i  (1'b0),
            .sum_o  (acc[g]),
            .cout_o (carry_unused[g])
        );
    end

    assign out_d = acc[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_eight_bit_multiplier.sv
// tb/tb_eight_bit_multiplier.sv - directed and random checks of the truncating multiplier
module tb_eight_bit_multiplier;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;

    int n_compared;
    int n_mismatched;

    logic [7:0] exp1;
    logic [7:0] exp2;

    eight_bit_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // exp1/exp2 track the results expected one and two falling edges after a pair is driven.
    task automatic step(input logic [7:0] na, input logic [7:0] nb, input bit release_rst,
                        input string tag);
        logic [15:0] full;
        @(negedge clk);
        expect_eq(tag, out, exp2);
        if (release_rst) rst_n = 1'b1;
        full = 16'(na) * 16'(nb);
        exp2 = exp1;
        exp1 = rst_n ? full[7:0] : 8'h00;
        a = na;
        b = nb;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b0;
        a     = 8'h5A;
        b     = 8'h03;
        exp1  = 8'h00;
        exp2  = 8'h00;

        for (int i = 0; i < 3; i++) step(8'h5A, 8'h03, 1'b0, "reset_hold");

        step(8'h00, 8'h00, 1'b1, "reset_release");
        step(8'h01, 8'h02, 1'b0, "post_reset");
        step(8'h04, 8'h10, 1'b0, "zero_x_zero");
        step(8'h40, 8'h0C, 1'b0, "one_x_two");
        step(8'h09, 8'h70, 1'b0, "four_x_16");
        step(8'hFF, 8'hFF, 1'b0, "trunc_768");
        step(8'h00, 8'h37, 1'b0, "trunc_1008");
        step(8'hA5, 8'h00, 1'b0, "ff_x_ff");
        step(8'h0D, 8'h0B, 1'b0, "zero_a");
        step(8'h0D, 8'h0B, 1'b0, "zero_b");
        for (int i = 0; i < 4; i++) step(8'h0D, 8'h0B, 1'b0, "hold_stable");

        // Asynchronous clear in the middle of the low clock phase, away from any edge.
        step(8'h03, 8'h05, 1'b0, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        expect_eq("async_clear", out, 8'h00);
        exp1 = 8'h00;
        exp2 = 8'h00;
        step(8'h77, 8'h33, 1'b0, "async_hold");
        step(8'h21, 8'h04, 1'b1, "async_release");

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                #2;
                rst_n = 1'b0;
                #1;
                expect_eq("midstream_clear", out, 8'h00);
                exp1 = 8'h00;
                exp2 = 8'h00;
                step(8'(($urandom_range(0, 255))), 8'(($urandom_range(0, 255))), 1'b0,
                     "midstream_hold");
                step(8'(($urandom_range(0, 255))), 8'(($urandom_range(0, 255))), 1'b1,
                     "midstream_release");
            end else begin
                step(8'(($urandom_range(0, 255))), 8'(($urandom_range(0, 255))), 1'b0,
                     "random");
            end
        end

        step(8'h00, 8'h00, 1'b0, "flush");
        step(8'h00, 8'h00, 1'b0, "flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
